// File: rtl/multdiv_unit_pkg.sv
// rtl/multdiv_unit_pkg.sv - shared types and constants for the multiply/divide unit
package multdiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

  localparam int DIV_ITERS = 32;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_div_core.sv
// rtl/multdiv_unit_div_core.sv - restoring divider datapath on unsigned magnitudes
module div_core (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        finish_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] mag_q_o,
  output logic [31:0] mag_r_o,
  output logic [5:0]  iter_o
);

  // {remainder, quotient}: dividend bits shift out of the low half as quotient bits shift in
  logic [63:0] rq_q, rq_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  iter_q, iter_d;
  logic [32:0] shifted;
  logic [32:0] diff;

  // One restoring step per cycle; load wins over finish, finish wins over step
  always_comb begin
    shifted = {rq_q[63:32], rq_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    rq_d    = rq_q;
    dvs_d   = dvs_q;
    iter_d  = iter_q;
    if (load_i) begin
      rq_d   = {32'd0, dividend_i};
      dvs_d  = divisor_i;
      iter_d = 6'd0;
    end else if (finish_i) begin
      iter_d = 6'd0;
    end else if (step_i) begin
      if (!diff[32]) begin
        rq_d = {diff[31:0], rq_q[30:0], 1'b1};
      end else begin
        rq_d = {shifted[31:0], rq_q[30:0], 1'b0};
      end
      iter_d = iter_q + 6'd1;
    end
  end

  // Divider state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rq_q   <= 64'd0;
      dvs_q  <= 32'd0;
      iter_q <= 6'd0;
    end else begin
      rq_q   <= rq_d;
      dvs_q  <= dvs_d;
      iter_q <= iter_d;
    end
  end

  assign mag_q_o = rq_q[31:0];
  assign mag_r_o = rq_q[63:32];
  assign iter_o  = iter_q;

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - MULT/MULTU/DIV/DIVU unit producing {hi,lo}; MULTDIV_EARLY_OUT_EN enables divide early-out
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  md_op_t      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] MUL_LAT_C  = 4'(MUL_LAT);
  localparam logic [5:0] LAST_ITER  = 6'(DIV_ITERS - 1);

  md_state_t   state_q, state_d;
  logic [3:0]  mul_cnt_q, mul_cnt_d;
  md_op_t      op_q;
  logic [31:0] a_q, b_q;
  logic        early_q;
  logic        done_q, done_d;
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic        div_load, div_step, div_finish;
  logic        early_in;
  logic        in_signed;
  logic [31:0] core_q, core_r;
  logic [5:0]  div_iter;

  assign in_signed = (op_i == MD_DIV);

`ifdef MULTDIV_EARLY_OUT_EN
  logic [31:0] a_mag_in, b_mag_in;
  assign a_mag_in = abs32(a_i, in_signed);
  assign b_mag_in = abs32(b_i, in_signed);
  assign early_in = (b_mag_in == 32'd0) || (a_mag_in < b_mag_in);
`else
  assign early_in = 1'b0;
`endif

  div_core u_div_core (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (div_load),
    .step_i     (div_step),
    .finish_i   (div_finish),
    .dividend_i (abs32(a_i, in_signed)),
    .divisor_i  (abs32(b_i, in_signed)),
    .mag_q_o    (core_q),
    .mag_r_o    (core_r),
    .iter_o     (div_iter)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      mul_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Next state, divider handshake and done; flush overrides everything
  always_comb begin
    state_d    = state_q;
    mul_cnt_d  = mul_cnt_q;
    accept     = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    div_finish = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          accept    = 1'b1;
          mul_cnt_d = 4'd0;
          if (op_i == MD_MULT || op_i == MD_MULTU) begin
            state_d = MUL;
          end else begin
            div_load = 1'b1;
            state_d  = early_in ? FIX : DIV;
          end
        end
      end
      MUL: begin
        mul_cnt_d = mul_cnt_q + 4'd1;
        if (mul_cnt_d == MUL_LAT_C) begin
          state_d   = IDLE;
          mul_cnt_d = 4'd0;
          done_d    = 1'b1;
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (div_iter == LAST_ITER) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d    = IDLE;
        div_finish = 1'b1;
        done_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d    = IDLE;
      mul_cnt_d  = 4'd0;
      div_step   = 1'b0;
      div_finish = 1'b1;
      done_d     = 1'b0;
    end
  end

  logic        res_signed;
  logic [63:0] a_ext, b_ext, product;
  logic [31:0] mq, mr, quo, rem;

  // Final results from the latched operands: full product, or sign-corrected quotient/remainder
  always_comb begin
    res_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    a_ext      = res_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext      = res_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    product    = a_ext * b_ext;
    if (early_q) begin
      mq = (b_q == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
      mr = abs32(a_q, res_signed);
    end else begin
      mq = core_q;
      mr = core_r;
    end
    quo = (res_signed && (a_q[31] ^ b_q[31])) ? (~mq + 32'd1) : mq;
    rem = (res_signed && a_q[31]) ? (~mr + 32'd1) : mr;
  end

  // Operand latch, done pulse and HI/LO result registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q    <= MD_MULT;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      early_q <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      if (accept) begin
        op_q    <= op_i;
        a_q     <= a_i;
        b_q     <= b_i;
        early_q <= early_in;
      end
      done_q <= done_d;
      if (done_d) begin
        if (state_q == MUL) begin
          hi_q <= product[63:32];
          lo_q <= product[31:0];
        end else begin
          hi_q <= rem;
          lo_q <= quo;
        end
      end
    end
  end

  assign ready_o = (state_q == IDLE);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule
